// File: rtl/rv_fetch.sv
// rv_fetch: instruction-fetch stage of the pipelined RV32I core.
// Holds the PC, issues one outstanding request at a time to instruction memory and
// drives the IF/ID register consumed by decode. A bubble is presented as IR = 32'h0.
//
// Ports
//   clk          pipeline clock, all state on posedge
//   rst          asynchronous active-high reset
//   imem_req     fetch request valid
//   imem_addr    fetch address (word aligned, always pc_q)
//   imem_gnt     memory accepts the request this cycle
//   imem_rvalid  read data valid
//   imem_rdata   instruction word
//   id_stall     decode cannot take a new IF/ID value
//   ex_redirect  taken branch/jump from EX: flush and refetch
//   ex_target    redirect target PC
//   if_id_ir     IF/ID instruction register
//   if_id_pc     IF/ID PC of if_id_ir
module rv_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        id_stall,
   input  logic        ex_redirect,
   input  logic [31:0] ex_target,
   output logic [31:0] if_id_ir,
   output logic [31:0] if_id_pc
);

   typedef enum logic [1:0] {
      StFetch,
      StWait,
      StHold,
      StDrop
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] hold_q, hold_d;
   logic [31:0] ir_q, ir_d;
   logic [31:0] ipc_q, ipc_d;
   logic [31:0] pc_inc;
   logic [31:0] target_aligned;

   assign pc_inc         = pc_q + 32'd4;
   assign target_aligned = ex_target & 32'hFFFF_FFFC;

   // Request is masked during reset and on a redirect so no handshake targets a dead PC.
   assign imem_req  = (state_q == StFetch) && !ex_redirect && !rst;
   assign imem_addr = pc_q;
   assign if_id_ir  = ir_q;
   assign if_id_pc  = ipc_q;

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      hold_d  = hold_q;
      ipc_d   = ipc_q;
      // No new instruction: hold under stall, otherwise insert a bubble.
      ir_d    = id_stall ? ir_q : 32'h0;

      if (ex_redirect) begin
         pc_d = target_aligned;
         ir_d = 32'h0;
         unique case (state_q)
            StFetch: state_d = StFetch;
            StHold:  state_d = StFetch;
            StWait:  state_d = imem_rvalid ? StFetch : StDrop;
            StDrop:  state_d = imem_rvalid ? StFetch : StDrop;
            default: state_d = StFetch;
         endcase
      end else begin
         unique case (state_q)
            StFetch: begin
               if (imem_gnt) begin
                  state_d = StWait;
               end
            end
            StWait: begin
               if (imem_rvalid) begin
                  if (!id_stall) begin
                     ir_d    = imem_rdata;
                     ipc_d   = pc_q;
                     pc_d    = pc_inc;
                     state_d = StFetch;
                  end else begin
                     hold_d  = imem_rdata;
                     state_d = StHold;
                  end
               end
            end
            StHold: begin
               if (!id_stall) begin
                  ir_d    = hold_q;
                  ipc_d   = pc_q;
                  pc_d    = pc_inc;
                  state_d = StFetch;
               end
            end
            StDrop: begin
               // Stale response from before a redirect; never reaches IF/ID.
               if (imem_rvalid) begin
                  state_d = StFetch;
               end
            end
            default: state_d = StFetch;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StFetch;
         pc_q    <= RESET_PC;
         hold_q  <= 32'h0;
         ir_q    <= 32'h0;
         ipc_q   <= 32'h0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         hold_q  <= hold_d;
         ir_q    <= ir_d;
         ipc_q   <= ipc_d;
      end
   end

endmodule
